// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that processes one nibble per clock,
// least-significant nibble first, with valid/ready handshakes on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

// 4-bit ripple-carry adder slice; the only arithmetic element of the adder.
module fulladd_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  // Ripple the carry through the four bit positions.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CW   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept_c;
  logic             finish_c;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       nib_sum;
  logic             nib_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Single nibble slice always works on the low nibble of the shift registers.
  fulladd_4 u_add (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry),
    .s  (nib_sum),
    .co (nib_co)
  );

  // Next-state decode; in_ready is high only in IDLE, so in_valid alone accepts there.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Operand capture, per-nibble shift/accumulate and final result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (accept_c) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      carry <= nib_co;
      cnt   <= cnt + CW'(1);
      sum   <= WIDTH'({nib_sum, sum} >> 4);
      if (finish_c) begin
        c_out <= nib_co;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow from operand sign bits captured at accept and the final sum sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept_c) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      ovf   <= 1'b0;
    end else if (finish_c) begin
      ovf   <= (a_msb == b_msb) & (nib_sum[3] != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4 instances).
// Define SERIAL_ADD_OVF_EN to also exercise the overflow output.
module tb_nibble_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
  logic [W-1:0] a, b, sum;
  logic         in_valid4, in_ready4, c_in4, out_valid4, out_ready4, c_out4, busy4;
  logic [3:0]   a4, b4, sum4;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf, ovf4;
`endif

  nibble_serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c_in(c_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .c_out(c_out4), .busy(busy4)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf4)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain wide addition and signed range test.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 32767) || (s < -32768);
  endfunction

  // Transaction-level model: accept in idle, result due NIB edges later, held until taken.
  bit           m_active = 0;
  bit           m_done   = 0;
  int           m_age    = 0;
  logic [W-1:0] m_sum    = '0;
  logic         m_cout   = 1'b0;
  logic         m_ovf    = 1'b0;
  bit           started  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 0;
      m_done   <= 0;
      m_age    <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active         <= 1;
        m_age            <= 0;
        {m_cout, m_sum}  <= ref_add(a, b, c_in);
        m_ovf            <= ref_ovf(a, b, c_in);
      end
    end else if (!m_done) begin
      m_age <= m_age + 1;
      if (m_age + 1 == NIB) m_done <= 1;
    end else if (out_ready) begin
      m_active <= 0;
      m_done   <= 0;
    end
  end

  // Compare DUT against the model on every falling edge once out of initial reset.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(!m_active));
      chk("busy", 32'(busy), 32'(m_active));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      chk("sum_known", 32'($isunknown({sum, c_out})), 32'(0));
      if (m_done) begin
        chk("sum", 32'(sum), 32'(m_sum));
        chk("c_out", 32'(c_out), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  // Accept instants observed at the DUT boundary.
  time acc_t[$];
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc_t.push_back($time);
  end

  task automatic start16(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    @(posedge clk); #1;
    a = ta; b = tb; c_in = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run16(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic [W-1:0] es, input logic ec);
    int lat;
    start16(ta, tb, tc);
    wait_done16(lat);
    chk({name, "_latency"}, 32'(lat), 32'(4));
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(c_out), 32'(ec));
    @(posedge clk); @(negedge clk);
    chk({name, "_ready_back"}, 32'(in_ready), 32'(1));
    chk({name, "_valid_drop"}, 32'(out_valid), 32'(0));
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic run16_ovf(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    start16(ta, tb, 1'b0);
    wait_done16(lat);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(c_out), 32'(ec));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk); @(negedge clk);
  endtask
`endif

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; c_in4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(c_out), 32'(0));
    chk("rst4_in_ready", 32'(in_ready4), 32'(1));
    chk("rst4_sum", 32'(sum4), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    started = 1;

    // Basic add, and full carry ripple through every nibble.
    run16("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run16("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run16("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Backpressure: result held, new operands ignored while DONE.
    out_ready = 1'b0;
    start16(16'h00F0, 16'h0F10, 1'b0);
    wait_done16(lat);
    chk("bp_latency", 32'(lat), 32'(4));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      @(negedge clk);
      chk("bp_sum", 32'(sum), 32'h1000);
      chk("bp_cout", 32'(c_out), 32'(0));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'(0));
    chk("bp_release_ready", 32'(in_ready), 32'(1));

    // Reset on the second RUN edge aborts the operation cleanly.
    start16(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(c_out), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    run16("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // Throughput with in_valid and out_ready held high: NIB+2 cycles per op.
    acc_t.delete();
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h00F1; c_in = 1'b0; in_valid = 1'b1;
    repeat (14) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    chk("thr_count", 32'(acc_t.size() >= 3), 32'(1));
    if (acc_t.size() >= 3) begin
      chk("thr_gap1", 32'(acc_t[1] - acc_t[0]), 32'(60));
      chk("thr_gap2", 32'(acc_t[2] - acc_t[1]), 32'(60));
    end

`ifdef SERIAL_ADD_OVF_EN
    run16_ovf("ovf_pos", 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run16_ovf("ovf_neg", 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    run16_ovf("ovf_none", 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
`endif

    // WIDTH=4 instance: single-nibble operation completes one edge after accept.
    @(posedge clk); #1;
    a4 = 4'h9; b4 = 4'h8; c_in4 = 1'b1; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("w4_running", 32'(out_valid4), 32'(0));
    chk("w4_busy", 32'(busy4), 32'(1));
    @(posedge clk); @(negedge clk);
    chk("w4_valid", 32'(out_valid4), 32'(1));
    chk("w4_sum", 32'(sum4), 32'h2);
    chk("w4_cout", 32'(c_out4), 32'(1));
`ifdef SERIAL_ADD_OVF_EN
    chk("w4_ovf", 32'(ovf4), 32'(1));
`endif
    @(posedge clk); @(negedge clk);
    chk("w4_ready_back", 32'(in_ready4), 32'(1));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
